// File: rtl/logic_unit_pkg.sv
// Shared types for the logic-unit arbiter: opcodes, legality check, FSM states.
// No logic of its own; no latency; no backpressure.
// Imported by logic_unit_arbiter and logic_unit_rr_pick.
package logic_unit_pkg;

    typedef logic [2:0] logic_op_t;

    localparam logic_op_t LOGIC_OP_AND = 3'b000;
    localparam logic_op_t LOGIC_OP_OR  = 3'b001;
    localparam logic_op_t LOGIC_OP_XOR = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    function automatic logic is_legal_op(input logic_op_t op);
        return (op == LOGIC_OP_AND) || (op == LOGIC_OP_OR) || (op == LOGIC_OP_XOR);
    endfunction

endpackage

// File: rtl/logic_unit_rr_pick.sv
// Round-robin picker: first asserted request after ptr, wrapping modulo NUM_REQ.
// Purely combinational, zero latency.
// No backpressure; the caller decides whether the pick is accepted.
module logic_unit_rr_pick
    import logic_unit_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDXW    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDXW-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant_onehot,
    output logic [IDXW-1:0]    grant_idx,
    output logic               any
);

    logic [IDXW:0] pos;

    // Scan from farthest to nearest so the nearest hit after ptr overwrites the rest.
    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        any          = 1'b0;
        pos          = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            pos = {1'b0, ptr} + (IDXW+1)'(k);
            if (pos >= (IDXW+1)'(NUM_REQ)) begin
                pos = pos - (IDXW+1)'(NUM_REQ);
            end
            if (req[pos[IDXW-1:0]]) begin
                grant_idx = pos[IDXW-1:0];
                any       = 1'b1;
            end
        end
        if (any) begin
            grant_onehot[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Shares one AND/OR/XOR logic unit between NUM_REQ requesters, round-robin.
// Accept-to-response: RESULT_LATENCY+1 cycles (legal op), 1 cycle (illegal op).
// One op in flight; req_ready low while busy; response held until rsp_ready.
module logic_unit_arbiter
    import logic_unit_pkg::*;
#(
    parameter int OPERAND_WIDTH  = 32,
    parameter int NUM_REQ        = 4,
    parameter int RESULT_LATENCY = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [3*NUM_REQ-1:0]             req_op,
    input  logic [OPERAND_WIDTH*NUM_REQ-1:0] req_lhs,
    input  logic [OPERAND_WIDTH*NUM_REQ-1:0] req_rhs,
    output logic [NUM_REQ-1:0]               rsp_valid,
    input  logic [NUM_REQ-1:0]               rsp_ready,
    output logic [OPERAND_WIDTH-1:0]         rsp_result,
    output logic                             rsp_error,
    output logic [2:0]                       lu_op,
    output logic [OPERAND_WIDTH-1:0]         lu_lhs,
    output logic [OPERAND_WIDTH-1:0]         lu_rhs,
    input  logic [OPERAND_WIDTH-1:0]         lu_result,
    output logic                             busy
);

    localparam int         IDXW     = $clog2(NUM_REQ);
    localparam logic [3:0] CNT_INIT = 4'(RESULT_LATENCY - 1);

    arb_state_t               state_q, state_d;
    logic [IDXW-1:0]          rr_ptr_q;
    logic [IDXW-1:0]          grant_q;
    logic [3:0]               cnt_q;
    logic_op_t                lu_op_q;
    logic [OPERAND_WIDTH-1:0] lu_lhs_q, lu_rhs_q;
    logic [OPERAND_WIDTH-1:0] rsp_result_q;
    logic                     rsp_error_q;

    logic [NUM_REQ-1:0]       pick_onehot;
    logic [IDXW-1:0]          pick_idx;
    logic                     pick_any;
    logic_op_t                sel_op;
    logic [OPERAND_WIDTH-1:0] sel_lhs, sel_rhs;
    logic                     accept;
    logic                     rsp_hs;

    logic_unit_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req          (req_valid),
        .ptr          (rr_ptr_q),
        .grant_onehot (pick_onehot),
        .grant_idx    (pick_idx),
        .any          (pick_any)
    );

    assign sel_op  = req_op[3*int'(pick_idx) +: 3];
    assign sel_lhs = req_lhs[OPERAND_WIDTH*int'(pick_idx) +: OPERAND_WIDTH];
    assign sel_rhs = req_rhs[OPERAND_WIDTH*int'(pick_idx) +: OPERAND_WIDTH];
    assign accept  = (state_q == IDLE) && pick_any;
    assign rsp_hs  = (state_q == RESP) && rsp_ready[grant_q];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = is_legal_op(sel_op) ? EXEC : RESP;
            EXEC:    if (cnt_q == 4'd0) state_d = RESP;
            RESP:    if (rsp_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE) ? pick_onehot : '0;
        rsp_valid = '0;
        if (state_q == RESP) begin
            rsp_valid[grant_q] = 1'b1;
        end
        busy = (state_q != IDLE);
    end

    // lu_* only move on a legal accept, so the unit never sees a spurious change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q     <= IDXW'(NUM_REQ - 1);
            grant_q      <= '0;
            cnt_q        <= '0;
            lu_op_q      <= '0;
            lu_lhs_q     <= '0;
            lu_rhs_q     <= '0;
            rsp_result_q <= '0;
            rsp_error_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        grant_q <= pick_idx;
                        if (is_legal_op(sel_op)) begin
                            lu_op_q  <= sel_op;
                            lu_lhs_q <= sel_lhs;
                            lu_rhs_q <= sel_rhs;
                            cnt_q    <= CNT_INIT;
                        end else begin
                            rsp_result_q <= '0;
                            rsp_error_q  <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    if (cnt_q == 4'd0) begin
                        rsp_result_q <= lu_result;
                        rsp_error_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_hs) begin
                        rr_ptr_q <= grant_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign lu_op      = lu_op_q;
    assign lu_lhs     = lu_lhs_q;
    assign lu_rhs     = lu_rhs_q;
    assign rsp_result = rsp_result_q;
    assign rsp_error  = rsp_error_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench: a request-side model predicts grants and responses into a queue,
// a response monitor pops and compares; directed phases followed by random traffic.
module tb_logic_unit_arbiter;

    localparam int W   = 8;
    localparam int N   = 3;
    localparam int LAT = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [3*N-1:0] req_op;
    logic [W*N-1:0] req_lhs, req_rhs;
    logic [W-1:0]   rsp_result, lu_lhs, lu_rhs, lu_result;
    logic [2:0]     lu_op;
    logic           rsp_error, busy;

    logic [N-1:0]   req_valid3, req_ready3, rsp_valid3, rsp_ready3;
    logic [3*N-1:0] req_op3;
    logic [W*N-1:0] req_lhs3, req_rhs3;
    logic [W-1:0]   rsp_result3, lu_lhs3, lu_rhs3, lu_result3;
    logic [2:0]     lu_op3;
    logic           rsp_error3, busy3;

    function automatic logic [W-1:0] golden(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a ^ b;
            default: return '0;
        endcase
    endfunction

    assign lu_result  = golden(lu_op, lu_lhs, lu_rhs);
    assign lu_result3 = golden(lu_op3, lu_lhs3, lu_rhs3);

    logic_unit_arbiter #(.OPERAND_WIDTH(W), .NUM_REQ(N), .RESULT_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_lhs(req_lhs), .req_rhs(req_rhs),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_error(rsp_error),
        .lu_op(lu_op), .lu_lhs(lu_lhs), .lu_rhs(lu_rhs), .lu_result(lu_result),
        .busy(busy)
    );

    logic_unit_arbiter #(.OPERAND_WIDTH(W), .NUM_REQ(N), .RESULT_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid3), .req_ready(req_ready3), .req_op(req_op3),
        .req_lhs(req_lhs3), .req_rhs(req_rhs3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_result(rsp_result3), .rsp_error(rsp_error3),
        .lu_op(lu_op3), .lu_lhs(lu_lhs3), .lu_rhs(lu_rhs3), .lu_result(lu_result3),
        .busy(busy3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    typedef struct {
        int         idx;
        logic [W-1:0] res;
        logic       err;
        int         due;
    } exp_t;

    typedef struct {
        int         idx;
        logic [W-1:0] res;
        logic       err;
    } srv_t;

    exp_t sbq[$];
    srv_t served[$];

    logic mon_en = 1'b0;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Request-side model: who should win, expected lu_* contents, busy.
    int          m_last, m_idx, m_due, a_win, a_j;
    logic        m_busy, a_err;
    logic [N-1:0] a_rdy;
    logic [2:0]  a_op;
    logic [W-1:0] a_l, a_r, a_res;
    logic [2*W+2:0] lu_exp;

    always @(negedge clk) begin
        if (!mon_en) begin
            m_last = N - 1;
            m_busy = 1'b0;
            lu_exp = '0;
            sbq.delete();
        end else begin
            a_win = -1;
            if (!m_busy) begin
                for (int k = 1; k <= N; k++) begin
                    a_j = (m_last + k) % N;
                    if (req_valid[a_j] && a_win < 0) a_win = a_j;
                end
            end
            a_rdy = '0;
            if (a_win >= 0) a_rdy[a_win] = 1'b1;
            chk("req_ready", 64'(req_ready), 64'(a_rdy));
            chk("busy", 64'(busy), 64'(m_busy));
            chk("lu_bus", 64'({lu_op, lu_lhs, lu_rhs}), 64'(lu_exp));
            if (m_busy) begin
                if (cyc >= m_due && rsp_ready[m_idx]) begin
                    m_busy = 1'b0;
                    m_last = m_idx;
                end
            end else if (a_win >= 0) begin
                a_op  = req_op[3*a_win +: 3];
                a_l   = req_lhs[W*a_win +: W];
                a_r   = req_rhs[W*a_win +: W];
                a_err = (a_op > 3'd2);
                a_res = a_err ? '0 : golden(a_op, a_l, a_r);
                m_busy = 1'b1;
                m_idx  = a_win;
                m_due  = cyc + (a_err ? 1 : LAT + 1);
                sbq.push_back('{a_win, a_res, a_err, m_due});
                if (!a_err) lu_exp = {a_op, a_l, a_r};
            end
        end
    end

    // Response monitor: pops the scoreboard on each response handshake.
    logic [N-1:0] r_exp;
    always @(negedge clk) begin
        if (mon_en) begin
            r_exp = '0;
            if (sbq.size() > 0 && cyc >= sbq[0].due) r_exp[sbq[0].idx] = 1'b1;
            chk("rsp_valid", 64'(rsp_valid), 64'(r_exp));
            if (r_exp != '0) begin
                chk("rsp_result", 64'(rsp_result), 64'(sbq[0].res));
                chk("rsp_error", 64'(rsp_error), 64'(sbq[0].err));
                if (rsp_ready[sbq[0].idx]) begin
                    served.push_back('{sbq[0].idx, rsp_result, rsp_error});
                    void'(sbq.pop_front());
                end
            end
        end
    end

    task automatic set_req(input int i, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        req_valid[i]        = 1'b1;
        req_op[3*i +: 3]    = op;
        req_lhs[W*i +: W]   = a;
        req_rhs[W*i +: W]   = b;
    endtask

    // One cycle: from posedge+1 to the next posedge+1, dropping accepted requests.
    task automatic step(input int n);
        logic [N-1:0] acc;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            req_valid = req_valid & ~acc;
        end
    endtask

    task automatic chk_served(input int i, input int idx, input logic [W-1:0] res, input logic err);
        if (served.size() > i) begin
            chk("served_idx", 64'(served[i].idx), 64'(idx));
            chk("served_res", 64'(served[i].res), 64'(res));
            chk("served_err", 64'(served[i].err), 64'(err));
        end else begin
            chk("served_missing", 64'(served.size()), 64'(i + 1));
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_rsp_result"}, 64'(rsp_result), 64'd0);
        chk({tag, "_rsp_error"}, 64'(rsp_error), 64'd0);
        chk({tag, "_lu_op"}, 64'(lu_op), 64'd0);
        chk({tag, "_lu_lhs"}, 64'(lu_lhs), 64'd0);
        chk({tag, "_lu_rhs"}, 64'(lu_rhs), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [N-1:0] acc;
        logic [2:0]   rop;

        rst = 1'b0;
        req_valid = '0; req_op = '0; req_lhs = '0; req_rhs = '0; rsp_ready = '1;
        req_valid3 = '0; req_op3 = '0; req_lhs3 = '0; req_rhs3 = '0; rsp_ready3 = '1;
        #3;
        chk_outputs_zero("reset");
        chk("reset_busy3", 64'(busy3), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        mon_en = 1'b1;

        // Contention from reset, with requester 0 re-raised while 1 is being served.
        served.delete();
        set_req(0, 3'b001, 8'hAA, 8'h0F);
        set_req(1, 3'b010, 8'hAA, 8'h0F);
        set_req(2, 3'b000, 8'hAA, 8'h0F);
        step(4);
        set_req(0, 3'b001, 8'h11, 8'h22);
        step(14);
        chk_served(0, 0, 8'hAF, 1'b0);
        chk_served(1, 1, 8'hA5, 1'b0);
        chk_served(2, 2, 8'h0A, 1'b0);
        chk_served(3, 0, 8'h33, 1'b0);

        // Single request.
        served.delete();
        set_req(0, 3'b000, 8'hF0, 8'h3C);
        step(5);
        chk_served(0, 0, 8'h30, 1'b0);

        // Response backpressure on requester 2.
        served.delete();
        rsp_ready = 3'b011;
        set_req(2, 3'b010, 8'h12, 8'h34);
        step(9);
        rsp_ready = '1;
        step(3);
        chk_served(0, 2, 8'h26, 1'b0);

        // Illegal opcode: no use of the unit, error response after one cycle.
        served.delete();
        set_req(1, 3'b101, 8'h55, 8'h66);
        step(4);
        chk_served(0, 1, 8'h00, 1'b1);

        // Reset in the middle of an op; afterwards requester 0 must win over 2.
        served.delete();
        set_req(0, 3'b000, 8'h0F, 8'hF5);
        step(1);
        mon_en = 1'b0;
        rst = 1'b0;
        #1;
        chk_outputs_zero("midrst");
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        mon_en = 1'b1;
        set_req(2, 3'b010, 8'h01, 8'h02);
        set_req(0, 3'b000, 8'h0F, 8'hF5);
        step(10);
        chk_served(0, 0, 8'h05, 1'b0);
        chk_served(1, 2, 8'h03, 1'b0);
        chk("midrst_count", 64'(served.size()), 64'd2);

        // Latency-3 instance: XOR FF,0F.
        req_valid3[0]   = 1'b1;
        req_op3[2:0]    = 3'b010;
        req_lhs3[W-1:0] = 8'hFF;
        req_rhs3[W-1:0] = 8'h0F;
        @(negedge clk);
        chk("l3_req_ready", 64'(req_ready3), 64'b001);
        @(posedge clk);
        #1;
        req_valid3 = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("l3_lu_bus", 64'({lu_op3, lu_lhs3, lu_rhs3}), 64'({3'b010, 8'hFF, 8'h0F}));
            chk("l3_rsp_valid_early", 64'(rsp_valid3), 64'd0);
            chk("l3_busy", 64'(busy3), 64'd1);
        end
        @(negedge clk);
        chk("l3_rsp_valid", 64'(rsp_valid3), 64'b001);
        chk("l3_rsp_result", 64'(rsp_result3), 64'hF0);
        chk("l3_rsp_error", 64'(rsp_error3), 64'd0);
        @(negedge clk);
        chk("l3_idle", 64'(busy3), 64'd0);
        @(posedge clk);
        #1;

        // Random traffic, including illegal ops, dropped requests and backpressure.
        served.delete();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i] || (req_valid[i] && $urandom_range(0, 19) == 0)) begin
                    req_valid[i] = 1'b0;
                end else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    rop = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
                    set_req(i, rop, 8'($urandom), 8'($urandom));
                end
                rsp_ready[i] = ($urandom_range(0, 2) != 0);
            end
        end
        req_valid = '0;
        rsp_ready = '1;
        step(10);
        chk("drain_empty", 64'(sbq.size()), 64'd0);
        chk("drain_idle", 64'(busy), 64'd0);
        chk("random_served", 64'(served.size() > 100), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Shares a single logic unit (AND/OR/XOR datapath) between NUM_REQ independent requesters.
- Arbitrates requests round-robin, registers the chosen operation and drives it into the unit.
- Waits a fixed RESULT_LATENCY cycles, then returns the result to the granted requester over a valid/ready response channel.
- Sits between the ALU front-end clients and the logic unit; illegal opcodes are rejected without using the unit.

Parameters:
- OPERAND_WIDTH, 32, bit width of lhs, rhs and result.
- NUM_REQ, 4, number of requesters (2..16).
- RESULT_LATENCY, 1, cycles from operands driven to lu_result valid (1..15).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous assert, active-low (0 = reset).
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester request accept; one-hot or zero.
- req_op  input  3*NUM_REQ  opcode of requester i at [3i+2:3i].
- req_lhs  input  OPERAND_WIDTH*NUM_REQ  left operand of requester i, packed the same way.
- req_rhs  input  OPERAND_WIDTH*NUM_REQ  right operand of requester i, packed the same way.
- rsp_valid  output  NUM_REQ  response valid, one-hot or zero.
- rsp_ready  input  NUM_REQ  per-requester response accept.
- rsp_result  output  OPERAND_WIDTH  result for the requester whose rsp_valid bit is set.
- rsp_error  output  1  set with rsp_valid when the opcode was illegal.
- lu_op  output  3  opcode to the logic unit.
- lu_lhs  output  OPERAND_WIDTH  left operand to the logic unit.
- lu_rhs  output  OPERAND_WIDTH  right operand to the logic unit.
- lu_result  input  OPERAND_WIDTH  result from the logic unit.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Opcodes: AND=3'b000, OR=3'b001, XOR=3'b010; 3'b011..3'b111 are illegal.
- Reset values (rst low, asynchronous):
  - state=IDLE; rr_ptr=NUM_REQ-1, so requester 0 wins first.
  - All outputs 0: req_ready, rsp_valid, rsp_result, rsp_error, lu_op, lu_lhs, lu_rhs, busy.
  - Latency counter 0.
- States are IDLE, EXEC and RESP.
- IDLE:
  - req_ready is driven combinationally, only in IDLE, and only to the winner.
  - Winner = first i with req_valid[i], scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
  - On accept (req_valid & req_ready), capture op/lhs/rhs and grant index.
  - Legal op: next state EXEC; load lu_* registers; counter=RESULT_LATENCY-1.
  - Illegal op: next state RESP; rsp_error=1; rsp_result=0; lu_* unchanged.
  - No req_valid: stay in IDLE. A requester may drop req_valid before it is granted, with no side effects.
- EXEC:
  - lu_* are held stable and the counter decrements each cycle.
  - At counter==0: capture lu_result into rsp_result, set rsp_error=0, go to RESP. EXEC therefore lasts exactly RESULT_LATENCY cycles.
- RESP:
  - rsp_valid[grant]=1; rsp_result and rsp_error are held until the handshake.
  - On rsp_ready[grant]: next state IDLE, rr_ptr=grant.
  - rsp_ready bits of other requesters are ignored. Backpressure of any length is allowed.
- Outside EXEC, lu_* hold their last values; they are never glitched to 0.
- Timing: request accept to rsp_valid is RESULT_LATENCY+1 cycles for a legal op and 1 cycle for an illegal op. Peak throughput is one op per RESULT_LATENCY+2 cycles.
- Requests arriving while busy are not accepted (req_ready=0) and must be held by the requester.
- Simultaneous requests: exactly one is granted per IDLE cycle. After serving i, requester i has lowest priority, so there is no starvation.
- Reset mid-operation: the in-flight op is dropped, no response is produced, and all state returns to reset values.
- Width rules: results are not extended or truncated; lu_result is captured verbatim.

Decomposition:
- Package logic_unit_pkg holds:
  - logic_op_t (3-bit) and constants LOGIC_OP_AND/OR/XOR;
  - function is_legal_op;
  - arbiter state enum typedef arb_state_t {IDLE, EXEC, RESP}.
- Sub-module logic_unit_rr_pick:
  - combinational round-robin picker, parameter NUM_REQ;
  - inputs req[NUM_REQ], ptr[$clog2(NUM_REQ)];
  - outputs grant_onehot, grant_idx, any.

Test Plan (OPERAND_WIDTH=8, NUM_REQ=3, RESULT_LATENCY=1, lu_result modelled by a behavioural logic unit):
- Single request: req0 AND 8'hF0,8'h3C -> req_ready[0] for 1 cycle; rsp_valid[0] 2 cycles after accept with rsp_result=8'h30, rsp_error=0.
- Contention: req0/1/2 all valid from reset (OR, XOR, AND on 8'hAA,8'h0F) -> grants in order 0,1,2 with results 8'hAF, 8'hA5, 8'h0A. Re-asserting req0 during req1's service leaves it granted only after req2.
- Illegal op: req1 op=3'b101 -> rsp_valid[1] 1 cycle after accept, rsp_error=1, rsp_result=0; lu_* unchanged from the prior op.
- Backpressure: rsp_ready[2]=0 for 5 cycles -> rsp_valid[2] and rsp_result stable, req_ready=0 throughout, busy=1; release -> IDLE next cycle.
- Latency: rerun with RESULT_LATENCY=3, XOR 8'hFF,8'h0F -> lu_* stable 3 cycles, rsp_result=8'hF0 at accept+4.
- Reset mid-op: assert rst low during EXEC -> outputs 0 immediately (async); after release no rsp_valid appears and requester 0 wins the next arbitration.
